// File: rtl/reaction_round_sequencer_if.sv
// Button and result bundle between the reaction-round sequencer and the wrapper logic.
// slave = sequencer side, master = button/display side.
interface reaction_round_sequencer_if;
    logic        btn_start;
    logic        btn_react;
    logic        go_led;
    logic [13:0] ms_count;
    logic        result_valid;
    logic        false_start;
    logic        timeout;
    logic [2:0]  state;
    logic [13:0] best_ms;

    modport master (
        output btn_start, btn_react,
        input  go_led, ms_count, result_valid, false_start, timeout, state, best_ms
    );

    modport slave (
        input  btn_start, btn_react,
        output go_led, ms_count, result_valid, false_start, timeout, state, best_ms
    );
endinterface

// File: rtl/reaction_round_sequencer.sv
// Reaction-time round controller: button sync/edge detect, 1 ms timebase, LFSR delay, round FSM.
// Optional best-time register enabled by defining BEST_TIME_EN.
module reaction_round_sequencer #(
    parameter int TICK_DIV     = 25000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = 9999
) (
    input  logic                        clk,
    input  logic                        rst,
    reaction_round_sequencer_if.slave   bus
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_GO   = 3'd2,
        S_DONE = 3'd3,
        S_FOUL = 3'd4,
        S_TOUT = 3'd5
    } state_t;

    state_t      r_state;
    logic [2:0]  r_start_sync;
    logic [2:0]  r_react_sync;
    logic        r_start_edge;
    logic        r_react_edge;
    logic [15:0] r_lfsr;
    logic [PW-1:0] r_presc;
    logic [15:0] r_delay;
    logic [13:0] r_ms;
    logic        r_go_led;
    logic        r_result_valid;
    logic        r_false_start;
    logic        r_timeout;

    logic        w_tick;
    logic        w_lfsr_fb;
    logic [15:0] w_delay_load;
    logic        w_ms_last;

    assign w_tick       = (r_presc == PW'(TICK_DIV - 1));
    assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_delay_load = 16'(MIN_DELAY_MS) + {{(16-RAND_BITS){1'b0}}, r_lfsr[RAND_BITS-1:0]};
    assign w_ms_last    = (r_ms == 14'(MAX_MS - 1));

    // Two sync flops, then a third flop whose registered compare gives the edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_sync <= '0;
            r_react_sync <= '0;
            r_start_edge <= 1'b0;
            r_react_edge <= 1'b0;
            r_lfsr       <= 16'hACE1;
        end else begin
            r_start_sync <= {r_start_sync[1:0], bus.btn_start};
            r_react_sync <= {r_react_sync[1:0], bus.btn_react};
            r_start_edge <= r_start_sync[1] & ~r_start_sync[2];
            r_react_edge <= r_react_sync[1] & ~r_react_sync[2];
            r_lfsr       <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_presc        <= '0;
            r_delay        <= '0;
            r_ms           <= '0;
            r_go_led       <= 1'b0;
            r_result_valid <= 1'b0;
            r_false_start  <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_presc        <= w_tick ? '0 : r_presc + PW'(1);
            case (r_state)
                S_IDLE, S_DONE, S_FOUL, S_TOUT: begin
                    if (r_start_edge) begin
                        r_state       <= S_WAIT;
                        r_delay       <= w_delay_load;
                        r_ms          <= '0;
                        r_presc       <= '0;
                        r_false_start <= 1'b0;
                        r_timeout     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // A press on the final tick is still a false start.
                    if (r_react_edge) begin
                        r_state       <= S_FOUL;
                        r_false_start <= 1'b1;
                        r_presc       <= '0;
                    end else if (w_tick) begin
                        if (r_delay <= 16'd1) begin
                            r_state  <= S_GO;
                            r_go_led <= 1'b1;
                            r_presc  <= '0;
                        end else begin
                            r_delay <= r_delay - 16'd1;
                        end
                    end
                end
                S_GO: begin
                    if (r_react_edge) begin
                        r_state        <= S_DONE;
                        r_go_led       <= 1'b0;
                        r_result_valid <= 1'b1;
                        r_presc        <= '0;
                    end else if (w_tick) begin
                        r_ms <= r_ms + 14'd1;
                        if (w_ms_last) begin
                            r_state   <= S_TOUT;
                            r_go_led  <= 1'b0;
                            r_timeout <= 1'b1;
                            r_presc   <= '0;
                        end
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_go_led      <= 1'b0;
                    r_false_start <= 1'b0;
                    r_timeout     <= 1'b0;
                    r_presc       <= '0;
                end
            endcase
        end
    end

`ifdef BEST_TIME_EN
    logic [13:0] r_best;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best <= 14'h3FFF;
        end else if (r_state == S_GO && r_react_edge && r_ms < r_best) begin
            r_best <= r_ms;
        end
    end

    assign bus.best_ms = r_best;
`else
    assign bus.best_ms = 14'h3FFF;
`endif

    assign bus.go_led       = r_go_led;
    assign bus.ms_count     = r_ms;
    assign bus.result_valid = r_result_valid;
    assign bus.false_start  = r_false_start;
    assign bus.timeout      = r_timeout;
    assign bus.state        = r_state;

endmodule

// File: tb/tb_reaction_round_sequencer.sv
// Scenario bench for reaction_round_sequencer with small timing parameters.
// Expected round results are queued when the react press is driven and popped at the state change.
module tb_reaction_round_sequencer;

    localparam int TD    = 4;
    localparam int MIN   = 2;
    localparam int RB    = 2;
    localparam int MAXMS = 20;

    typedef struct {
        logic [2:0]  st;
        logic [13:0] ms;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   rv_count = 0;
    int   go_cycles = 0;
    exp_t sb[$];
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    reaction_round_sequencer_if bus ();

    reaction_round_sequencer #(
        .TICK_DIV(TD), .MIN_DELAY_MS(MIN), .RAND_BITS(RB), .MAX_MS(MAXMS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference LFSR, taps 16,14,13,11; m_prev is the value the DUT held before the last edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    always @(negedge clk) begin
        if (bus.result_valid === 1'b1) rv_count <= rv_count + 1;
        if (bus.go_led === 1'b1) go_cycles <= go_cycles + 1;
    end

    task automatic start_to_wait(output int d_exp, output logic [13:0] ms_at_wait, output bit ok);
        @(negedge clk);
        bus.btn_start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.state === 3'd1) begin
                ok = 1'b1;
                break;
            end
        end
        d_exp = MIN + int'(m_prev[RB-1:0]);
        ms_at_wait = bus.ms_count;
        bus.btn_start = 1'b0;
    endtask

    task automatic wait_go(input int limit, output int cycles, output bit ok);
        cycles = 0;
        while (bus.go_led !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        ok = (bus.go_led === 1'b1);
    endtask

    task automatic wait_leave(input logic [2:0] st, input int limit, output int cycles, output bit ok);
        cycles = 0;
        while (bus.state === st && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        ok = (bus.state !== st);
    endtask

    task automatic react_after(input int d);
        repeat (d) @(negedge clk);
        bus.btn_react = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.btn_start = 1'b1;
        bus.btn_react = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.state); end
        total++; if (bus.ms_count !== 14'd0) begin bad++; $display("FAIL reset_ms got=%0d want=0", bus.ms_count); end
        total++; if (bus.go_led !== 1'b0) begin bad++; $display("FAIL reset_go got=%b want=0", bus.go_led); end
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b want=0", bus.result_valid); end
        total++; if (bus.false_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", bus.false_start); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL reset_to got=%b want=0", bus.timeout); end
        total++; if (bus.best_ms !== 14'h3FFF) begin bad++; $display("FAIL reset_best got=%h want=3fff", bus.best_ms); end
        bus.btn_start = 1'b0;
        bus.btn_react = 1'b0;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL post_reset_state got=%0d want=0", bus.state); end
    endtask

    task automatic test_normal();
        int d, cyc, rv0;
        bit ok;
        logic [13:0] ms0;
        exp_t e;
        start_to_wait(d, ms0, ok);
        total++; if (!ok) begin bad++; $display("FAIL normal_enter_wait got=%0d want=1", bus.state); end
        wait_go(4 * d + 16, cyc, ok);
        total++; if (!ok || cyc != TD * d) begin bad++; $display("FAIL normal_delay got=%0d want=%0d", cyc, TD * d); end
        total++; if (bus.state !== 3'd2) begin bad++; $display("FAIL normal_go_state got=%0d want=2", bus.state); end
        rv0 = rv_count;
        sb.push_back('{3'd3, 14'((26 + 3) / TD)});
        react_after(26);
        wait_leave(3'd2, 40, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL normal_leave_go got=%0d want=3", bus.state); end
        e = sb.pop_front();
        total++; if (bus.state !== e.st) begin bad++; $display("FAIL normal_state got=%0d want=%0d", bus.state, e.st); end
        total++; if (bus.ms_count !== e.ms) begin bad++; $display("FAIL normal_ms got=%0d want=%0d", bus.ms_count, e.ms); end
        total++; if (bus.result_valid !== 1'b1 || bus.go_led !== 1'b0) begin bad++; $display("FAIL normal_rv_go got=%b%b want=10", bus.result_valid, bus.go_led); end
        @(negedge clk);
        bus.btn_react = 1'b0;
        repeat (4) @(negedge clk);
        bus.btn_react = 1'b1;
        repeat (8) @(negedge clk);
        bus.btn_react = 1'b0;
        total++; if (rv_count - rv0 != 1) begin bad++; $display("FAIL normal_rv_pulses got=%0d want=1", rv_count - rv0); end
        total++; if (bus.state !== 3'd3 || bus.ms_count !== e.ms) begin bad++; $display("FAIL done_hold got=%0d/%0d want=3/%0d", bus.state, bus.ms_count, e.ms); end
    endtask

    task automatic test_false_start();
        int d, cyc, go0;
        bit ok;
        logic [13:0] ms0;
        exp_t e;
        start_to_wait(d, ms0, ok);
        total++; if (!ok || ms0 !== 14'd0) begin bad++; $display("FAIL b2b_wait got=%0d/%0d want=1/0", bus.state, ms0); end
        go0 = go_cycles;
        repeat (2) @(negedge clk);
        sb.push_back('{3'd4, 14'd0});
        bus.btn_react = 1'b1;
        wait_leave(3'd1, 12, cyc, ok);
        e = sb.pop_front();
        total++; if (bus.state !== e.st || bus.ms_count !== e.ms) begin bad++; $display("FAIL foul_state got=%0d/%0d want=%0d/%0d", bus.state, bus.ms_count, e.st, e.ms); end
        total++; if (bus.false_start !== 1'b1) begin bad++; $display("FAIL foul_flag got=%b want=1", bus.false_start); end
        total++; if (go_cycles != go0) begin bad++; $display("FAIL foul_go_seen got=%0d want=0", go_cycles - go0); end
        bus.btn_react = 1'b0;
        repeat (2) @(negedge clk);
        start_to_wait(d, ms0, ok);
        total++; if (!ok || bus.false_start !== 1'b0) begin bad++; $display("FAIL foul_restart got=%0d/%b want=1/0", bus.state, bus.false_start); end
        sb.push_back('{3'd4, 14'd0});
        bus.btn_react = 1'b1;
        wait_leave(3'd1, 12, cyc, ok);
        e = sb.pop_front();
        total++; if (bus.state !== e.st) begin bad++; $display("FAIL foul_again got=%0d want=%0d", bus.state, e.st); end
        bus.btn_react = 1'b0;
    endtask

    task automatic test_timeout();
        int d, cyc, rv0;
        bit ok;
        logic [13:0] ms0;
        exp_t e;
        start_to_wait(d, ms0, ok);
        wait_go(4 * d + 16, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL tout_go got=%b want=1", bus.go_led); end
        sb.push_back('{3'd5, 14'(MAXMS)});
        wait_leave(3'd2, TD * MAXMS + 20, cyc, ok);
        e = sb.pop_front();
        total++; if (bus.state !== e.st || bus.ms_count !== e.ms) begin bad++; $display("FAIL tout_state got=%0d/%0d want=%0d/%0d", bus.state, bus.ms_count, e.st, e.ms); end
        total++; if (cyc != TD * MAXMS) begin bad++; $display("FAIL tout_cycles got=%0d want=%0d", cyc, TD * MAXMS); end
        total++; if (bus.timeout !== 1'b1 || bus.go_led !== 1'b0) begin bad++; $display("FAIL tout_flags got=%b%b want=10", bus.timeout, bus.go_led); end
        rv0 = rv_count;
        @(negedge clk);
        bus.btn_react = 1'b1;
        repeat (8) @(negedge clk);
        bus.btn_react = 1'b0;
        total++; if (bus.state !== 3'd5 || bus.ms_count !== 14'(MAXMS) || rv_count != rv0) begin bad++; $display("FAIL tout_hold got=%0d/%0d want=5/%0d", bus.state, bus.ms_count, MAXMS); end
    endtask

    task automatic test_coincidence();
        int d, cyc;
        bit ok;
        logic [13:0] ms0;
        exp_t e;
        start_to_wait(d, ms0, ok);
        wait_go(4 * d + 16, cyc, ok);
        sb.push_back('{3'd3, 14'((16 + 3) / TD)});
        react_after(16);
        wait_leave(3'd2, 40, cyc, ok);
        e = sb.pop_front();
        total++; if (bus.state !== e.st || bus.ms_count !== e.ms) begin bad++; $display("FAIL coinc_go got=%0d/%0d want=%0d/%0d", bus.state, bus.ms_count, e.st, e.ms); end
        @(negedge clk);
        bus.btn_react = 1'b0;
        start_to_wait(d, ms0, ok);
        sb.push_back('{3'd4, 14'd0});
        react_after(TD * d - 4);
        wait_leave(3'd1, 20, cyc, ok);
        e = sb.pop_front();
        total++; if (bus.state !== e.st || bus.go_led !== 1'b0) begin bad++; $display("FAIL coinc_wait got=%0d/%b want=%0d/0", bus.state, bus.go_led, e.st); end
        @(negedge clk);
        bus.btn_react = 1'b0;
    endtask

    task automatic test_best();
        int d, cyc, m;
        bit ok;
        logic [13:0] ms0;
        logic [13:0] exp_best;
        int rounds[3] = '{9, 5, 12};
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_best = 14'h3FFF;
        for (int r = 0; r < 3; r++) begin
            m = rounds[r];
            start_to_wait(d, ms0, ok);
            wait_go(4 * d + 16, cyc, ok);
            sb.push_back('{3'd3, 14'(m)});
            react_after(TD * m - 3);
            wait_leave(3'd2, 80, cyc, ok);
            e = sb.pop_front();
            total++; if (bus.state !== e.st || bus.ms_count !== e.ms) begin bad++; $display("FAIL best_round%0d got=%0d/%0d want=%0d/%0d", r, bus.state, bus.ms_count, e.st, e.ms); end
`ifdef BEST_TIME_EN
            if (14'(m) < exp_best) exp_best = 14'(m);
`endif
            total++; if (bus.best_ms !== exp_best) begin bad++; $display("FAIL best_ms%0d got=%0d want=%0d", r, bus.best_ms, exp_best); end
            @(negedge clk);
            bus.btn_react = 1'b0;
        end
        start_to_wait(d, ms0, ok);
        wait_go(4 * d + 16, cyc, ok);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (bus.state !== 3'd0 || bus.go_led !== 1'b0) begin bad++; $display("FAIL rst_mid_go got=%0d/%b want=0/0", bus.state, bus.go_led); end
        total++; if (bus.best_ms !== 14'h3FFF) begin bad++; $display("FAIL rst_best got=%h want=3fff", bus.best_ms); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.btn_start = 1'b0;
        bus.btn_react = 1'b0;
        test_reset();
        test_normal();
        test_false_start();
        test_timeout();
        test_coincidence();
        test_best();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reaction_round_sequencer.md
Name: reaction_round_sequencer

Overview:
- Central controller for the reaction-time tester: sequences one round as arm, random wait, GO, measure, then result.
- Synchronises and edge-detects both push buttons, generates the 1 ms timebase and runs the round FSM.
- Drives the GO LED and publishes the measured reaction time in milliseconds.
- Sits between the `ui_in` button pins and the display/LED logic inside the top-level TinyTapeout wrapper; runs on the 25 MHz system clock.

Parameters:
- TICK_DIV, 25000: clk cycles per 1 ms tick (25 MHz / 1 kHz).
- MIN_DELAY_MS, 1000: fixed part of the random pre-GO delay, in ms.
- RAND_BITS, 11: LFSR bits added to the delay (0..2^RAND_BITS-1 ms).
- MAX_MS, 9999: reaction-count limit; reaching it ends the round as a timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_start  in  1  raw start button, asynchronous to clk.
- btn_react  in  1  raw reaction button, asynchronous to clk.
- go_led  out  1  high while in GO.
- ms_count  out  14  reaction time in ms; counts live in GO, frozen afterwards.
- result_valid  out  1  one-cycle pulse on entry to DONE.
- false_start  out  1  high while in FOUL.
- timeout  out  1  high while in TOUT.
- state  out  3  current FSM state encoding.
- best_ms  out  14  best time of the session (see Optional Feature).

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE(0), ms_count=0, go_led=0, result_valid=0, false_start=0, timeout=0, best_ms=14'h3FFF.
  - Prescaler=0, both synchroniser chains=0, LFSR=16'hACE1.
  - Reset asserted mid-round aborts the round immediately.
- Inputs:
  - Each button passes through 2-FF synchroniser, then a rising-edge detector.
  - Edge pulse is 1 cycle, asserted on the 3rd rising clk edge after the pin rises.
  - No debounce in this block.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk cycle in all states; never reaches zero.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick=1 in the cycle it equals TICK_DIV-1, then wraps to 0.
  - Cleared on every state transition, so the first ms after a transition is always full length.
- State encoding: IDLE=0, WAIT=1, GO=2, DONE=3, FOUL=4, TOUT=5.
- IDLE:
  - start_edge -> WAIT.
  - On that edge: delay_cnt = MIN_DELAY_MS + LFSR[RAND_BITS-1:0] (16-bit), ms_count=0.
- WAIT:
  - delay_cnt decrements on each tick.
  - On a tick with delay_cnt==1 -> GO.
  - react_edge -> FOUL. If react_edge and the final tick occur in the same cycle, FOUL wins.
  - start_edge is ignored.
- GO:
  - go_led=1; ms_count increments on each tick.
  - react_edge -> DONE, ms_count frozen. If react_edge and a tick coincide, no increment is applied.
  - On a tick with ms_count==MAX_MS-1: ms_count becomes MAX_MS -> TOUT.
  - react_edge beats timeout when simultaneous.
  - start_edge is ignored.
- DONE / FOUL / TOUT:
  - Hold all outputs; react_edge ignored.
  - start_edge -> WAIT with a fresh delay load and ms_count=0.
  - result_valid fires only on the GO->DONE transition cycle (registered, 1 cycle).
- Latency: react pin rise to result_valid = 4 clk edges (3 for edge detection + 1 for the registered transition).
- Illegal state encodings (6, 7) return to IDLE on the next clk.

Optional Feature:
- Macro: BEST_TIME_EN.
- Defined:
  - best_ms updates on GO->DONE entry when the frozen ms_count < best_ms, in the same cycle as result_valid.
  - Reset only by rst.
  - FOUL and TOUT never update it.
- Undefined: best_ms is tied to constant 14'h3FFF and no register is inferred.

Test Plan (TICK_DIV=4, MIN_DELAY_MS=2, RAND_BITS=2, MAX_MS=20):
1. Reset check: assert rst for 3 cycles with buttons high -> all outputs at reset values, state=0; after release with buttons low, state stays 0.
2. Normal round: pulse start, hold LFSR-derived delay D (2..5 ms), press react 7 ticks after go_led rises -> state=3, ms_count=7, result_valid high exactly 1 cycle, go_led=0.
3. False start: press react during WAIT -> state=4, false_start=1, go_led never asserted; a subsequent start -> state=1, false_start=0.
4. Timeout: enter GO, never press -> ms_count=20, state=5, timeout=1; react then ignored (state remains 5).
5. Coincidence: react_edge aligned with the tick where ms_count would go 4->5 -> DONE with ms_count=4; react_edge aligned with the final WAIT tick -> FOUL.
6. BEST_TIME_EN defined: rounds of 9, 5 and 12 ms -> best_ms = 9, 5, 5; rst mid-GO -> state=0, best_ms=14'h3FFF. With the macro undefined -> best_ms constant 14'h3FFF.
